// File: rtl/powlib_busburst.sv
// Burst write generator: turns one command into cmdlen sequential bus beats,
// with optional per-beat data increment, then pulses done for one cycle.
module powlib_busburst #(
  parameter int B_AW = 2,
  parameter int B_DW = 4,
  parameter int LW   = 4,
  parameter int EDBG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_AW-1:0] cmdaddr,
  input  logic [B_DW-1:0] cmddata,
  input  logic [LW-1:0]   cmdlen,
  input  logic            cmdinc,
  input  logic            cmdvld,
  output logic            cmdrdy,
  output logic [B_DW-1:0] wrdata,
  output logic [B_AW-1:0] wraddr,
  output logic            wrvld,
  input  logic            wrrdy,
  output logic            done,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [LW-1:0] remain;
  logic          inc;

  // All outputs are registered alongside the state, so wrrdy/cmdvld never reach an output combinationally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      remain <= '0;
      inc    <= 1'b0;
      wraddr <= '0;
      wrdata <= '0;
      wrvld  <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      cmdrdy <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmdvld) begin
            wraddr <= cmdaddr;
            wrdata <= cmddata;
            remain <= cmdlen;
            inc    <= cmdinc;
            cmdrdy <= 1'b0;
            busy   <= 1'b1;
            if (cmdlen != '0) begin
              state <= RUN;
              wrvld <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (wrrdy) begin
            wraddr <= wraddr + 1'b1;
            if (inc) begin
              wrdata <= wrdata + 1'b1;
            end
            remain <= remain - 1'b1;
            if (remain == LW'(1)) begin
              state <= DONE;
              wrvld <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          cmdrdy <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          wrvld  <= 1'b0;
          done   <= 1'b0;
          busy   <= 1'b0;
          cmdrdy <= 1'b1;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Simulation-only beat trace.
  if (EDBG != 0) begin : g_dbg
    always @(posedge clk) begin
      if (rst && state == RUN && wrrdy) begin
        $display("powlib_busburst beat addr=%0h data=%0h", wraddr, wrdata);
      end
    end
  end
`endif

endmodule
